// File: rtl/video_timing_pkg.sv
// Shared DPI video timing defaults, counter widths and lock-state encoding.
package video_timing_pkg;

    localparam int H_TOTAL_DEF         = 864;
    localparam int FIELD_LINES_MIN_DEF = 311;
    localparam int FIELD_LINES_MAX_DEF = 314;

    localparam int PIXEL_W = 11;
    localparam int LINE_W  = 10;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_e;

    // A vSync arriving near a line boundary marks an odd field; mid-line marks even.
    function automatic logic vsync_parity(input logic [PIXEL_W-1:0] pc,
                                          input logic [PIXEL_W-1:0] lo,
                                          input logic [PIXEL_W-1:0] hi);
        return (pc < lo) || (pc >= hi);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Rising-edge detector that samples its input only on enabled cycles.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic sig_in,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = prev_q;
        if (en) begin
            prev_d = sig_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = en & sig_in & ~prev_q;

endmodule

// File: rtl/field_line_tracker.sv
// Tracks pixel/line position and interlaced field parity of a DPI stream and
// reports lock once alternating fields of legal length are seen.
// Optional debug port lastFieldLines is enabled by FIELD_LINE_TRACKER_DEBUG_EN.
//
// state  | meaning
// SEARCH | no field reference; next vSync starts a measurement
// TRACK  | one field boundary seen; waiting for a matching second field
// LOCKED | field sequence confirmed; locked output high
module field_line_tracker
    import video_timing_pkg::*;
#(
    parameter int H_TOTAL         = H_TOTAL_DEF,
    parameter int FIELD_LINES_MIN = FIELD_LINES_MIN_DEF,
    parameter int FIELD_LINES_MAX = FIELD_LINES_MAX_DEF
) (
    input  logic               pixelClockX6,
    input  logic               reset,
    input  logic               pixelClockX1_en,
    input  logic               hSync,
    input  logic               vSync,
    output logic [LINE_W-1:0]  fieldLine,
    output logic               isFieldOdd,
    output logic [PIXEL_W-1:0] pixelCount,
    output logic               locked
`ifdef FIELD_LINE_TRACKER_DEBUG_EN
    ,
    output logic [LINE_W-1:0]  lastFieldLines
`endif
);

    localparam logic [PIXEL_W-1:0] ODD_LO    = PIXEL_W'(H_TOTAL / 4);
    localparam logic [PIXEL_W-1:0] ODD_HI    = PIXEL_W'((3 * H_TOTAL) / 4);
    localparam logic [PIXEL_W-1:0] LINES_MIN = PIXEL_W'(FIELD_LINES_MIN);
    localparam logic [PIXEL_W-1:0] LINES_MAX = PIXEL_W'(FIELD_LINES_MAX);
    localparam logic [PIXEL_W-1:0] PIXEL_SAT = '1;
    localparam logic [LINE_W-1:0]  LINE_SAT  = '1;

    logic h_rise;
    logic v_rise;

    sync_edge_detect u_hsync_edge (
        .clk    (pixelClockX6),
        .reset  (reset),
        .en     (pixelClockX1_en),
        .sig_in (hSync),
        .rise   (h_rise)
    );

    sync_edge_detect u_vsync_edge (
        .clk    (pixelClockX6),
        .reset  (reset),
        .en     (pixelClockX1_en),
        .sig_in (vSync),
        .rise   (v_rise)
    );

    logic [PIXEL_W-1:0] pixel_count_q, pixel_count_d;
    logic [LINE_W-1:0]  field_line_q,  field_line_d;
    logic               field_odd_q,   field_odd_d;
    logic               locked_q,      locked_d;
    lock_state_e        state_q,       state_d;

    logic [PIXEL_W-1:0] line_count;
    logic [LINE_W-1:0]  line_inc;
    logic               new_odd;
    logic               count_ok;
    logic               parity_ok;

    always_comb begin
        pixel_count_d = pixel_count_q;
        field_line_d  = field_line_q;
        field_odd_d   = field_odd_q;
        state_d       = state_q;

        line_count = {1'b0, field_line_q} + PIXEL_W'(1);
        line_inc   = (field_line_q == LINE_SAT) ? field_line_q : field_line_q + LINE_W'(1);
        // Coincident edges are judged as if the line had just restarted.
        new_odd    = h_rise ? 1'b1 : vsync_parity(pixel_count_q, ODD_LO, ODD_HI);
        count_ok   = (line_count >= LINES_MIN) && (line_count <= LINES_MAX);
        parity_ok  = (new_odd != field_odd_q);

        if (pixelClockX1_en) begin
            if (h_rise) begin
                pixel_count_d = '0;
            end else if (pixel_count_q != PIXEL_SAT) begin
                pixel_count_d = pixel_count_q + PIXEL_W'(1);
            end

            if (v_rise) begin
                field_line_d = '0;
                field_odd_d  = new_odd;
            end else if (h_rise) begin
                field_line_d = line_inc;
            end

            case (state_q)
                SEARCH: begin
                    if (v_rise) begin
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (v_rise && parity_ok && count_ok) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (v_rise) begin
                        if (!(parity_ok && count_ok)) begin
                            state_d = SEARCH;
                        end
                    end else if (h_rise && ({1'b0, line_inc} > LINES_MAX)) begin
                        state_d = SEARCH;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

`ifdef FIELD_LINE_TRACKER_DEBUG_EN
    logic [LINE_W-1:0] last_lines_q, last_lines_d;

    always_comb begin
        last_lines_d = last_lines_q;
        if (v_rise) begin
            last_lines_d = line_count[LINE_W-1:0];
        end
    end

    always_ff @(posedge pixelClockX6) begin
        if (reset) begin
            last_lines_q <= '0;
        end else begin
            last_lines_q <= last_lines_d;
        end
    end

    assign lastFieldLines = last_lines_q;
`endif

    always_ff @(posedge pixelClockX6) begin
        if (reset) begin
            pixel_count_q <= '0;
            field_line_q  <= '0;
            field_odd_q   <= 1'b0;
            locked_q      <= 1'b0;
            state_q       <= SEARCH;
        end else begin
            pixel_count_q <= pixel_count_d;
            field_line_q  <= field_line_d;
            field_odd_q   <= field_odd_d;
            locked_q      <= locked_d;
            state_q       <= state_d;
        end
    end

    assign pixelCount = pixel_count_q;
    assign fieldLine  = field_line_q;
    assign isFieldOdd = field_odd_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_field_line_tracker.sv
// Directed bench for field_line_tracker: PAL field sequences, lock/unlock,
// saturation, enable gating and mid-field reset.
module tb_field_line_tracker;

    localparam int SHORT_LINE = 4;
    localparam int MID_PIXEL  = 432;

    logic        pixelClockX6;
    logic        reset;
    logic        pixelClockX1_en;
    logic        hSync;
    logic        vSync;
    logic [9:0]  fieldLine;
    logic        isFieldOdd;
    logic [10:0] pixelCount;
    logic        locked;
`ifdef FIELD_LINE_TRACKER_DEBUG_EN
    logic [9:0]  lastFieldLines;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int gap      = 0;

    field_line_tracker dut (
        .pixelClockX6    (pixelClockX6),
        .reset           (reset),
        .pixelClockX1_en (pixelClockX1_en),
        .hSync           (hSync),
        .vSync           (vSync),
        .fieldLine       (fieldLine),
        .isFieldOdd      (isFieldOdd),
        .pixelCount      (pixelCount),
        .locked          (locked)
`ifdef FIELD_LINE_TRACKER_DEBUG_EN
        ,
        .lastFieldLines  (lastFieldLines)
`endif
    );

    initial pixelClockX6 = 1'b0;
    always #5 pixelClockX6 = ~pixelClockX6;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One enabled pixel sample, preceded by `gap` disabled cycles.
    task automatic step(input logic h, input logic v);
        repeat (gap) begin
            @(negedge pixelClockX6);
            pixelClockX1_en = 1'b0;
        end
        @(negedge pixelClockX6);
        hSync = h;
        vSync = v;
        pixelClockX1_en = 1'b1;
        @(posedge pixelClockX6);
        #1;
    endtask

    task automatic step_off(input logic h, input logic v);
        @(negedge pixelClockX6);
        hSync = h;
        vSync = v;
        pixelClockX1_en = 1'b0;
        @(posedge pixelClockX6);
        #1;
    endtask

    task automatic hline(input int len);
        step(1'b1, 1'b0);
        repeat (len - 1) step(1'b0, 1'b0);
    endtask

    task automatic lines(input int n);
        repeat (n) hline(SHORT_LINE);
    endtask

    task automatic vs_top();
        step(1'b1, 1'b1);
    endtask

    task automatic tail();
        repeat (SHORT_LINE - 1) step(1'b0, 1'b0);
    endtask

    // Start a line and run to the mid-line vSync point, then raise vSync.
    task automatic vs_mid();
        step(1'b1, 1'b0);
        repeat (MID_PIXEL) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        pixelClockX1_en = 1'b0;
        hSync = 1'b0;
        vSync = 1'b0;
        repeat (3) @(posedge pixelClockX6);
        #1;
        check("rst_line", fieldLine, 0);
        check("rst_pix", pixelCount, 0);
        check("rst_odd", isFieldOdd, 0);
        check("rst_lock", locked, 0);
`ifdef FIELD_LINE_TRACKER_DEBUG_EN
        check("rst_dbg", lastFieldLines, 0);
`endif
        @(negedge pixelClockX6);
        reset = 1'b0;

        // enable gating: state holds while pixelClockX1_en is low
        hline(SHORT_LINE);
        check("en_pix0", pixelCount, 3);
        check("en_line0", fieldLine, 1);
        repeat (3) step_off(1'b1, 1'b0);
        check("en_hold_pix", pixelCount, 3);
        check("en_hold_line", fieldLine, 1);
        step(1'b0, 1'b0);
        check("en_resume_pix", pixelCount, 4);
        step(1'b1, 1'b0);
        check("en_hedge_line", fieldLine, 2);
        check("en_hedge_pix", pixelCount, 0);

        // PAL sequence at one enable in six
        gap = 5;
        vs_top();
        check("e1_lock", locked, 0);
        check("e1_odd", isFieldOdd, 1);
        tail();
        lines(311);
        vs_mid();
        check("e2_lock", locked, 1);
        check("e2_odd", isFieldOdd, 0);
        check("e2_line", fieldLine, 0);
`ifdef FIELD_LINE_TRACKER_DEBUG_EN
        check("e2_dbg", lastFieldLines, 313);
`endif
        gap = 0;
        tail();
        lines(311);
        check("e3_pre_line", fieldLine, 311);
        vs_top();
        check("e3_lock", locked, 1);
        check("e3_odd", isFieldOdd, 1);
        check("coinc_line", fieldLine, 0);
        check("coinc_pix", pixelCount, 0);
`ifdef FIELD_LINE_TRACKER_DEBUG_EN
        check("e3_dbg", lastFieldLines, 312);
`endif

        // repeated top-of-line vSync breaks lock and returns to SEARCH
        tail();
        lines(311);
        vs_top();
        check("e4_lock", locked, 0);
        check("e4_odd", isFieldOdd, 1);
        tail();
        lines(311);
        vs_mid();
        check("e5_search_lock", locked, 0);
        tail();
        lines(311);
        vs_top();
        check("e6_relock", locked, 1);

        // withheld vSync: lock lost past the maximum, line count saturates
        tail();
        lines(314);
        check("ovr_line314", fieldLine, 314);
        check("ovr_lock314", locked, 1);
        hline(SHORT_LINE);
        check("ovr_line315", fieldLine, 315);
        check("ovr_lock315", locked, 0);
        lines(708);
        check("sat_line", fieldLine, 1023);
        step(1'b1, 1'b0);
        repeat (2060) step(1'b0, 1'b0);
        check("sat_line_hold", fieldLine, 1023);
        check("sat_pix", pixelCount, 2047);

        // relock, then reset mid-field with the enable low
        vs_top();
        tail();
        lines(311);
        vs_mid();
        check("pre_rst_lock", locked, 1);
        tail();
        lines(150);
        check("pre_rst_line", fieldLine, 150);
        @(negedge pixelClockX6);
        pixelClockX1_en = 1'b0;
        reset = 1'b1;
        @(posedge pixelClockX6);
        #1;
        check("mrst_line", fieldLine, 0);
        check("mrst_pix", pixelCount, 0);
        check("mrst_odd", isFieldOdd, 0);
        check("mrst_lock", locked, 0);
`ifdef FIELD_LINE_TRACKER_DEBUG_EN
        check("mrst_dbg", lastFieldLines, 0);
`endif
        @(negedge pixelClockX6);
        reset = 1'b0;
        lines(311);
        vs_top();
        check("post_rst_e1_lock", locked, 0);
        check("post_rst_e1_odd", isFieldOdd, 1);
        tail();
        lines(311);
        vs_mid();
        check("post_rst_e2_lock", locked, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/field_line_tracker.md
FIELD_LINE_TRACKER -- requirements
Module: field_line_tracker

Interface
REQ-001 SHALL have parameter H_TOTAL, default 864, pixel clocks per line.
REQ-002 SHALL have parameter FIELD_LINES_MIN, default 311, minimum legal lines per field.
REQ-003 SHALL have parameter FIELD_LINES_MAX, default 314, maximum legal lines per field.
REQ-004 SHALL have port pixelClockX6, input, 1 bit; the single clock.
REQ-005 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-006 SHALL have port pixelClockX1_en, input, 1 bit; pixel-rate enable, one pixelClockX6 cycle in six.
REQ-007 SHALL have port hSync, input, 1 bit; active-high DPI horizontal sync, already synchronous to pixelClockX6.
REQ-008 SHALL have port vSync, input, 1 bit; active-high DPI vertical sync, already synchronous to pixelClockX6.
REQ-009 SHALL have port fieldLine, output, 10 bits; current line within the field, 0-based.
REQ-010 SHALL have port isFieldOdd, output, 1 bit; parity of the current field.
REQ-011 SHALL have port pixelCount, output, 11 bits; pixel position within the line.
REQ-012 SHALL have port locked, output, 1 bit; high when interlaced field sequence is confirmed.

Function
REQ-013 SHALL sample hSync and vSync, and evaluate all logic, only in cycles where pixelClockX1_en is high; all state holds otherwise.
REQ-014 SHALL detect a rising edge as input high now, low at the previous enabled sample.
REQ-015 SHALL update all outputs from registers in the same clock edge that ends the enabled cycle: one pixelClockX6 cycle of latency.
REQ-016 SHALL clear pixelCount to 0 on an hSync edge; otherwise it increments, saturating at 2047.
REQ-017 SHALL increment fieldLine on an hSync edge, saturating at 1023.
REQ-018 SHALL clear fieldLine to 0 on a vSync edge; vSync takes priority over a simultaneous hSync edge.
REQ-019 SHALL set isFieldOdd on a vSync edge to 1 when pixelCount < H_TOTAL/4 or >= 3*H_TOTAL/4, and to 0 otherwise (mid-line vSync).
REQ-020 SHALL treat simultaneous hSync and vSync edges as pixelCount 0, giving isFieldOdd=1 and fieldLine=0.
REQ-021 SHALL implement the lock FSM states SEARCH, TRACK and LOCKED.
REQ-022 SHALL, in SEARCH, move to TRACK on a vSync edge.
REQ-023 SHALL, in TRACK, move to LOCKED on a vSync edge with parity opposite to the previous field and with fieldLine+1 in [FIELD_LINES_MIN, FIELD_LINES_MAX]; any other vSync edge SHALL keep it in TRACK and restart measurement.
REQ-024 SHALL, in LOCKED, move to SEARCH on a vSync edge that repeats the previous parity or gives a line count out of range, or when fieldLine passes FIELD_LINES_MAX without a vSync edge.
REQ-025 SHALL drive locked high only in LOCKED; counters keep running in all states.

Reset
REQ-026 SHALL, while reset is high on a pixelClockX6 edge, set fieldLine=0, pixelCount=0, isFieldOdd=0, locked=0, FSM=SEARCH, and both edge-history registers=0, regardless of pixelClockX1_en.
REQ-027 SHALL discard an in-progress field measurement when reset is asserted mid-field; the first vSync edge after reset SHALL only enter TRACK.

Configuration
REQ-028 SHALL, with FIELD_LINE_TRACKER_DEBUG_EN defined, add output lastFieldLines[9:0], which holds fieldLine+1 latched at each vSync edge and is 0 after reset.
REQ-029 SHALL, without FIELD_LINE_TRACKER_DEBUG_EN defined, omit that port and its register, with all other behaviour unchanged.

Structure
REQ-030 SHALL place the H_TOTAL, FIELD_LINES_MIN and FIELD_LINES_MAX defaults and the lock-state typedef (SEARCH/TRACK/LOCKED) in shared package video_timing_pkg.
REQ-031 SHALL implement the enable-gated rising-edge detection once as sub-module sync_edge_detect, instantiated for hSync and for vSync.

Verification
REQ-032 SHALL check: PAL stream of 864-pixel lines, with vSync at pixel 0 after 312 lines and at pixel 432 after 313 lines -> locked rises at the second vSync edge; isFieldOdd alternates 1/0.
REQ-033 SHALL check: hSync and vSync edges coincide -> fieldLine=0, isFieldOdd=1, pixelCount=0 one cycle later.
REQ-034 SHALL check: while locked, two consecutive fields both with vSync at pixel 0 -> locked falls at the second vSync edge and FSM enters SEARCH.
REQ-035 SHALL check: while locked, vSync is withheld -> locked falls when fieldLine reaches 315, and fieldLine saturates at 1023 if hSync continues.
REQ-036 SHALL check: reset pulsed at line 150 with pixelClockX1_en low -> all outputs 0 on the next edge, then two further vSync edges are needed to regain locked.
REQ-037 SHALL check: with FIELD_LINE_TRACKER_DEBUG_EN defined, a 313-line field -> lastFieldLines=313 after its closing vSync edge.
